// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse transmitter: symbol codes, FSM
// states, element lengths in units and width helpers.
package morse_pkg;

    localparam int unsigned UNIT_W = 3;

    typedef logic [UNIT_W-1:0] units_t;

    typedef enum logic [1:0] {
        SYM_DOT  = 2'b00,
        SYM_DASH = 2'b01,
        SYM_LGAP = 2'b10,
        SYM_WGAP = 2'b11
    } sym_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_MARK  = 2'b01,
        ST_SPACE = 2'b10,
        ST_RGAP  = 2'b11
    } state_t;

    localparam units_t DOT_U     = 3'd1;
    localparam units_t DASH_U    = 3'd3;
    localparam units_t ELEM_SP_U = 3'd1;
    localparam units_t LGAP_U    = 3'd2;
    localparam units_t WGAP_U    = 3'd6;
    localparam units_t RGAP_U    = 3'd7;

    // State and unit count an element starts with
    typedef struct packed {
        state_t state;
        units_t units;
    } load_t;

    // Bit width needed to hold 0..v-1, never narrower than one bit
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    // Entry state for a symbol: marks for dot/dash, pure spaces for gaps
    function automatic load_t sym_load(input logic [1:0] code);
        load_t ld;
        ld.state = ST_SPACE;
        ld.units = WGAP_U;
        case (sym_t'(code))
            SYM_DOT:  begin ld.state = ST_MARK;  ld.units = DOT_U;  end
            SYM_DASH: begin ld.state = ST_MARK;  ld.units = DASH_U; end
            SYM_LGAP: begin ld.state = ST_SPACE; ld.units = LGAP_U; end
            SYM_WGAP: begin ld.state = ST_SPACE; ld.units = WGAP_U; end
        endcase
        return ld;
    endfunction

endpackage

// File: rtl/morse_seq_tx_if.sv
// Command/status bundle between the command logic (master) and the Morse
// transmitter (slave).
interface morse_seq_tx_if
    import morse_pkg::*;
#(
    parameter int unsigned MAX_SYM = 16
);
    localparam int unsigned MSG_W = 2 * MAX_SYM;
    localparam int unsigned LEN_W = clog2_min1(MAX_SYM + 1);
    localparam int unsigned IDX_W = clog2_min1(MAX_SYM);

    logic             start;
    logic [MSG_W-1:0] msg;
    logic [LEN_W-1:0] len;
    logic             repeat_en;
    logic             abort;
    logic             pin_out;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] sym_idx;

    modport master (
        output start, msg, len, repeat_en, abort,
        input  pin_out, busy, done, sym_idx
    );

    modport slave (
        input  start, msg, len, repeat_en, abort,
        output pin_out, busy, done, sym_idx
    );

endinterface

// File: rtl/morse_unit_tick.sv
// Morse time-unit prescaler: tick is high during the last clock of every
// unit; clr restarts the unit so each element gets whole units.
module morse_unit_tick
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int unsigned PW = clog2_min1(UNIT_CYCLES);
    localparam logic [PW-1:0] LAST = PW'(UNIT_CYCLES - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_n;
    logic          tick_n;

    // tick is registered from the next prescaler value so it lines up with presc == LAST
    always_comb begin
        presc_n = presc_q + PW'(1);
        if (clr || (presc_q == LAST)) begin
            presc_n = '0;
        end
        tick_n = (presc_n == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            tick    <= 1'b0;
        end else begin
            presc_q <= presc_n;
            tick    <= tick_n;
        end
    end

endmodule

// File: rtl/morse_seq_tx.sv
// Morse message transmitter: walks a latched list of dot/dash/gap symbols
// and drives the output pin with unit-based timing, optionally looping.
module morse_seq_tx
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 12_500_000,
    parameter int unsigned MAX_SYM     = 16
) (
    input logic           clk,
    input logic           rst_n,
    morse_seq_tx_if.slave bus
);
    localparam int unsigned MSG_W = 2 * MAX_SYM;
    localparam int unsigned LEN_W = clog2_min1(MAX_SYM + 1);
    localparam int unsigned IDX_W = clog2_min1(MAX_SYM);

    state_t           state_q, state_n;
    units_t           units_q, units_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic [MSG_W-1:0] msg_q, msg_n;
    logic [LEN_W-1:0] len_q, len_n;
    logic             rep_q, rep_n;
    logic             done_n;
    logic             pin_q, busy_q, done_q;

    logic             tick;
    logic             expire_c;
    logic             clr_c;
    logic             last_c;
    logic [IDX_W-1:0] idx_inc_c;
    logic [LEN_W-1:0] len_clamp_c;
    load_t            ld_new_c, ld_first_c, ld_next_c;

    // Prescaler held cleared in IDLE and restarted on every element boundary
    morse_unit_tick #(
        .UNIT_CYCLES(UNIT_CYCLES)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr_c),
        .tick (tick)
    );

    always_comb begin
        len_clamp_c = (bus.len > LEN_W'(MAX_SYM)) ? LEN_W'(MAX_SYM) : bus.len;
        idx_inc_c   = idx_q + IDX_W'(1);
        last_c      = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
        expire_c    = tick && (units_q == UNIT_W'(1));
        clr_c       = (state_q == ST_IDLE) || bus.abort || expire_c;
        ld_new_c    = sym_load(bus.msg[1:0]);
        ld_first_c  = sym_load(msg_q[1:0]);
        ld_next_c   = sym_load(msg_q[{idx_inc_c, 1'b0} +: 2]);
    end

    // Next-state logic; abort overrides everything and suppresses done
    always_comb begin
        state_n = state_q;
        units_n = units_q;
        idx_n   = idx_q;
        msg_n   = msg_q;
        len_n   = len_q;
        rep_n   = rep_q;
        done_n  = 1'b0;

        if (bus.abort) begin
            state_n = ST_IDLE;
            units_n = '0;
            idx_n   = '0;
        end else begin
            if (tick && (state_q != ST_IDLE)) begin
                units_n = units_q - UNIT_W'(1);
            end
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && (bus.len != '0)) begin
                        msg_n   = bus.msg;
                        len_n   = len_clamp_c;
                        rep_n   = bus.repeat_en;
                        idx_n   = '0;
                        state_n = ld_new_c.state;
                        units_n = ld_new_c.units;
                    end
                end
                ST_MARK: begin
                    if (expire_c) begin
                        state_n = ST_SPACE;
                        units_n = ELEM_SP_U;
                    end
                end
                ST_SPACE: begin
                    if (expire_c) begin
                        if (!last_c) begin
                            idx_n   = idx_inc_c;
                            state_n = ld_next_c.state;
                            units_n = ld_next_c.units;
                        end else begin
                            done_n = 1'b1;
                            if (rep_q) begin
                                state_n = ST_RGAP;
                                units_n = RGAP_U;
                            end else begin
                                state_n = ST_IDLE;
                                units_n = '0;
                                idx_n   = '0;
                            end
                        end
                    end
                end
                ST_RGAP: begin
                    if (expire_c) begin
                        idx_n   = '0;
                        state_n = ld_first_c.state;
                        units_n = ld_first_c.units;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs registered from next-state values for zero start latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            units_q <= '0;
            idx_q   <= '0;
            msg_q   <= '0;
            len_q   <= '0;
            rep_q   <= 1'b0;
            pin_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            units_q <= units_n;
            idx_q   <= idx_n;
            msg_q   <= msg_n;
            len_q   <= len_n;
            rep_q   <= rep_n;
            pin_q   <= (state_n == ST_MARK);
            busy_q  <= (state_n != ST_IDLE);
            done_q  <= done_n;
        end
    end

    assign bus.pin_out = pin_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.sym_idx = idx_q;

endmodule

// File: tb/tb_morse_seq_tx.sv
// Directed bench for morse_seq_tx: three instances (U=4, U=2 with repeat,
// U=1) checked cycle by cycle against hand-derived timing.
module tb_morse_seq_tx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    morse_seq_tx_if #(.MAX_SYM(16)) ia ();
    morse_seq_tx_if #(.MAX_SYM(4))  ib ();
    morse_seq_tx_if #(.MAX_SYM(16)) ic ();

    morse_seq_tx #(.UNIT_CYCLES(4), .MAX_SYM(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    morse_seq_tx #(.UNIT_CYCLES(2), .MAX_SYM(4))  dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    morse_seq_tx #(.UNIT_CYCLES(1), .MAX_SYM(16)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ic));

    int n_vec = 0;
    int n_err = 0;

    // Per-cycle capture: bit0 pin_out, bit1 done, bit2 busy
    logic [2:0] cap     [0:199];
    int         cap_idx [0:199];
    int         runs    [0:31];
    int         n_runs;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int which, input logic v);
        case (which)
            0:       ia.start = v;
            1:       ib.start = v;
            default: ic.start = v;
        endcase
    endtask

    task automatic set_abort(input int which, input logic v);
        case (which)
            0:       ia.abort = v;
            1:       ib.abort = v;
            default: ic.abort = v;
        endcase
    endtask

    task automatic sample(input int which, input int k);
        case (which)
            0: begin
                cap[k]     = {ia.busy, ia.done, ia.pin_out};
                cap_idx[k] = int'(ia.sym_idx);
            end
            1: begin
                cap[k]     = {ib.busy, ib.done, ib.pin_out};
                cap_idx[k] = int'(ib.sym_idx);
            end
            default: begin
                cap[k]     = {ic.busy, ic.done, ic.pin_out};
                cap_idx[k] = int'(ic.sym_idx);
            end
        endcase
    endtask

    // Pulse start so it is sampled at the next edge (E0); returns in cycle 0
    task automatic launch(input int which);
        set_start(which, 1'b1);
        step();
        set_start(which, 1'b0);
    endtask

    // Record n cycles; optionally pulse start or abort during a given cycle
    task automatic capture(input int which, input int n, input int poke_at, input int abort_at);
        for (int k = 0; k < n; k++) begin
            sample(which, k);
            if (k == poke_at)  set_start(which, 1'b1);
            if (k == abort_at) set_abort(which, 1'b1);
            step();
            set_start(which, 1'b0);
            set_abort(which, 1'b0);
        end
    endtask

    function automatic int count_bit(input int b, input int lo, input int hi);
        int c = 0;
        for (int k = lo; k <= hi; k++) if (cap[k][b]) c++;
        return c;
    endfunction

    function automatic int first_bit(input int b, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) if (cap[k][b]) return k;
        return -1;
    endfunction

    task automatic get_runs(input int lo, input int hi);
        int cur = 0;
        n_runs = 0;
        for (int k = lo; k <= hi; k++) begin
            if (cap[k][0]) begin
                cur++;
            end else if (cur > 0) begin
                if (n_runs < 32) runs[n_runs] = cur;
                n_runs++;
                cur = 0;
            end
        end
        if (cur > 0) begin
            if (n_runs < 32) runs[n_runs] = cur;
            n_runs++;
        end
    endtask

    logic [1:0]  sos     [0:10];
    int          sos_run [0:8];
    logic [31:0] m;

    initial begin
        sos     = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
        sos_run = '{4, 4, 4, 12, 12, 12, 4, 4, 4};

        rst_n = 1'b0;
        ia.start = 1'b0; ia.msg = '0; ia.len = '0; ia.repeat_en = 1'b0; ia.abort = 1'b0;
        ib.start = 1'b0; ib.msg = '0; ib.len = '0; ib.repeat_en = 1'b0; ib.abort = 1'b0;
        ic.start = 1'b0; ic.msg = '0; ic.len = '0; ic.repeat_en = 1'b0; ic.abort = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        check_val("rst_pin",  int'(ia.pin_out), 0);
        check_val("rst_busy", int'(ia.busy),    0);
        check_val("rst_done", int'(ia.done),    0);
        check_val("rst_idx",  int'(ia.sym_idx), 0);

        // Reset asserted in the middle of a dash mark
        ia.msg = 32'h1;
        ia.len = 5'd1;
        launch(0);
        step();
        step();
        check_val("pre_rst_mark", int'(ia.pin_out), 1);
        rst_n = 1'b0;
        #1;
        check_val("async_rst_pin",  int'(ia.pin_out), 0);
        check_val("async_rst_busy", int'(ia.busy),    0);
        check_val("async_rst_done", int'(ia.done),    0);
        check_val("async_rst_idx",  int'(ia.sym_idx), 0);
        step();
        step();
        rst_n = 1'b1;
        repeat (6) step();
        check_val("post_rst_busy", int'(ia.busy),    0);
        check_val("post_rst_pin",  int'(ia.pin_out), 0);

        // Single dot, U=4
        ia.msg = 32'h0;
        ia.len = 5'd1;
        launch(0);
        capture(0, 12, -1, -1);
        check_val("dot_pin_first", first_bit(0, 0, 11), 0);
        check_val("dot_pin_count", count_bit(0, 0, 11), 4);
        check_val("dot_pin_low4",  int'(cap[4][0]),     0);
        check_val("dot_done_at",   first_bit(1, 0, 11), 8);
        check_val("dot_done_cnt",  count_bit(1, 0, 11), 1);
        check_val("dot_busy_cnt",  count_bit(2, 0, 11), 8);
        check_val("dot_busy_e8",   int'(cap[8][2]),     0);

        // Abort coinciding with the final unit expiry: no done
        launch(0);
        capture(0, 12, -1, 7);
        check_val("abrt_busy_e7",  int'(cap[7][2]),     1);
        check_val("abrt_busy_e8",  int'(cap[8][2]),     0);
        check_val("abrt_done_cnt", count_bit(1, 0, 11), 0);

        // len = 0 is ignored
        ia.len = 5'd0;
        launch(0);
        capture(0, 4, -1, -1);
        check_val("len0_busy", count_bit(2, 0, 3), 0);

        // SOS with a stray start in the middle of the message
        m = '0;
        for (int i = 0; i < 11; i++) m[2*i +: 2] = sos[i];
        ia.msg = m;
        ia.len = 5'd11;
        launch(0);
        capture(0, 120, 20, -1);
        check_val("sos_pin_total", count_bit(0, 0, 119), 60);
        check_val("sos_done_at",   first_bit(1, 0, 119), 112);
        check_val("sos_done_cnt",  count_bit(1, 0, 119), 1);
        check_val("sos_busy_111",  int'(cap[111][2]), 1);
        check_val("sos_busy_112",  int'(cap[112][2]), 0);
        check_val("sos_idx_50",    cap_idx[50],  5);
        check_val("sos_idx_111",   cap_idx[111], 10);
        check_val("sos_idx_112",   cap_idx[112], 0);
        get_runs(0, 119);
        check_val("sos_n_runs", n_runs, 9);
        for (int r = 0; r < 9; r++) check_val($sformatf("sos_run%0d", r), runs[r], sos_run[r]);

        // len above MAX_SYM clamps to 16 dots
        ia.msg = 32'h0;
        ia.len = 5'd31;
        launch(0);
        capture(0, 136, -1, -1);
        check_val("clamp_done_at", first_bit(1, 0, 135), 128);
        check_val("clamp_pin_cnt", count_bit(0, 0, 135), 64);
        check_val("clamp_idx_127", cap_idx[127], 15);
        get_runs(0, 135);
        check_val("clamp_n_runs", n_runs, 16);

        // Repeat mode, U=2, single dash, abort in the third repeat gap
        ib.msg       = 8'h01;
        ib.len       = 3'd1;
        ib.repeat_en = 1'b1;
        launch(1);
        ib.repeat_en = 1'b0;
        capture(1, 90, -1, 55);
        check_val("rep_done_1",    first_bit(1, 0, 89),  8);
        check_val("rep_done_2",    first_bit(1, 9, 89),  30);
        check_val("rep_done_3",    first_bit(1, 31, 89), 52);
        check_val("rep_pin_0_29",  count_bit(0, 0, 29),  12);
        check_val("rep_pin_2nd",   first_bit(0, 6, 89),  22);
        check_val("rep_gap_busy",  count_bit(2, 8, 21),  14);
        check_val("rep_busy_55",   int'(cap[55][2]),     1);
        check_val("rep_busy_56",   int'(cap[56][2]),     0);
        check_val("rep_post_busy", count_bit(2, 56, 89), 0);
        check_val("rep_post_done", count_bit(1, 53, 89), 0);
        check_val("rep_idx_56",    cap_idx[56],          0);

        // U=1: dot, word gap, dot
        ic.msg = 32'h0000_000C;
        ic.len = 5'd3;
        launch(2);
        capture(2, 14, -1, -1);
        check_val("u1_pin_first", first_bit(0, 0, 13), 0);
        check_val("u1_pin_e1",    int'(cap[1][0]),     0);
        check_val("u1_pin_2nd",   first_bit(0, 1, 13), 8);
        check_val("u1_pin_cnt",   count_bit(0, 0, 13), 2);
        check_val("u1_done_at",   first_bit(1, 0, 13), 10);
        check_val("u1_idx_5",     cap_idx[5],          1);
        check_val("u1_idx_9",     cap_idx[9],          2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/morse_seq_tx.md
# morse_seq_tx

Parametrised Morse-pattern transmitter: accepts a message of up to MAX_SYM encoded symbols (dot, dash, letter gap, word gap) with a start pulse and drives a single output pin with standard unit-based Morse timing. It supersedes the fixed one-hot SSS/SOS/OSO/OOO pattern driver and sits between command logic and the LED/buzzer pin. It adds arbitrary messages, a programmable time unit, repeat mode, abort, and busy/done status.

## Interface
- UNIT_CYCLES, default 12_500_000: clock cycles per Morse unit; legal values ≥ 1.
- MAX_SYM, default 16: maximum symbols per message; legal values ≥ 1.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- msg  in  2*MAX_SYM  symbol i is msg[2i+1:2i]; symbol 0 is sent first.
- len  in  clog2(MAX_SYM+1)  symbol count; 0 means no message; values above MAX_SYM are clamped to MAX_SYM.
- repeat_en  in  1  loop the message until abort; sampled with start.
- abort  in  1  stop immediately; highest priority.
- pin_out  out  1  Morse output, registered, active-high mark.
- busy  out  1  high from accepted start until return to IDLE.
- done  out  1  one-cycle pulse at the end of each message pass.
- sym_idx  out  clog2(MAX_SYM)  index of the symbol being sent; 0 in IDLE.

## Operation
- Symbol codes:
  - 00 DOT: mark for 1 unit, then space for 1 unit.
  - 01 DASH: mark for 3 units, then space for 1 unit.
  - 10 LGAP: space for 2 units. With the preceding element space this gives the standard 3-unit letter gap.
  - 11 WGAP: space for 6 units, giving a 7-unit word gap.
- States are IDLE, MARK, SPACE, RGAP.
- IDLE:
  - A start with len ≠ 0 and abort = 0 latches msg, the clamped len and repeat_en, sets idx = 0, and loads symbol 0.
  - A start with len = 0 is ignored.
- Symbol load:
  - DOT or DASH goes to MARK with 1 or 3 units.
  - LGAP or WGAP goes to SPACE with 2 or 6 units.
- MARK:
  - When its units expire, go to SPACE with 1 unit.
- SPACE:
  - When its units expire and idx < len-1: increment idx and load the next symbol.
  - When its units expire and idx = len-1 with repeat off: go to IDLE and pulse done.
  - When its units expire and idx = len-1 with repeat on: pulse done and go to RGAP with 7 units.
- RGAP:
  - When its units expire, set idx = 0 and load symbol 0.
  - busy stays high throughout.
- pin_out is 1 only in MARK.
- start while busy is ignored. Inputs msg, len and repeat_en are not re-sampled mid-message.
- abort in any state:
  - Next edge: IDLE, pin_out = 0, busy = 0, sym_idx = 0.
  - No done pulse, even if abort coincides with the final unit expiry.
- Unit timer:
  - Prescaler counts 0..UNIT_CYCLES-1.
  - It is cleared on every state entry, so each unit is exactly UNIT_CYCLES cycles.
- Counter widths:
  - Prescaler: clog2(UNIT_CYCLES), minimum 1.
  - Unit counter: 3 bits (maximum 7).

## Timing
- Reset values: pin_out = 0, busy = 0, done = 0, sym_idx = 0, state IDLE, all counters 0.
- Start latency: start sampled at edge E0 means the state, pin_out and busy update at E0, so zero-cycle latency to the first element.
- Let U = UNIT_CYCLES. An element of n units occupies exactly n·U cycles.
- done:
  - Asserted for the single cycle following the last cycle of the final SPACE, coincident with busy falling (no repeat) or with RGAP entry (repeat).
- Message duration with no repeat: sum of symbol units × U, where DOT = 2, DASH = 4, LGAP = 2, WGAP = 6.
- done is registered and never asserted in the same cycle as a start acceptance.

## Structure
- Package morse_pkg holds:
  - Symbol codes SYM_DOT, SYM_DASH, SYM_LGAP, SYM_WGAP.
  - State encodings.
  - Unit constants DOT_U = 1, DASH_U = 3, ELEM_SP_U = 1, LGAP_U = 2, WGAP_U = 6, RGAP_U = 7.
- Sub-module morse_unit_tick:
  - Parameter UNIT_CYCLES; inputs clk, rst_n, clr.
  - Output tick pulses in the last cycle of each unit.
  - The FSM consumes tick to decrement the unit counter.

## Test plan
- Reset behaviour: U = 4, assert rst_n low mid-MARK → pin_out, busy, done and sym_idx are all 0 immediately, and stay 0 after release with no start.
- Single dot: U = 4, len = 1, msg = DOT, start at E0 → pin_out high E0..E0+3, low E0+4..E0+7, done = 1 in cycle E0+8 only, busy low from E0+8.
- SOS: U = 4, len = 11, message DOT×3, LGAP, DASH×3, LGAP, DOT×3 → done at E0+112, and pin_out high for a total of 60 cycles in runs of 4, 4, 4, 12, 12, 12, 4, 4, 4.
- Repeat: U = 2, len = 1, DASH, repeat_en = 1 → done pulses at E0+8, E0+30 and E0+52, with pin high at E0..E0+5 and E0+22..E0+27; then abort → IDLE next edge with no further done.
- Edge cases:
  - start with len = 0 → busy stays 0.
  - start during busy → no effect on the pattern.
  - len = 31 with MAX_SYM = 16 → exactly 16 symbols are sent.
  - U = 1 → dot mark is 1 cycle.
